// File: rtl/pipe_chain_if.sv
// Handshake and observation signals of a pipe_chain instance.
// master drives the chain (producer/controller side); slave is the chain itself.
interface pipe_chain_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 5
);
  localparam int unsigned OccW = $clog2(STAGES + 1);

  logic                    in_valid;
  logic [WIDTH-1:0]        in_data;
  logic                    in_ready;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic                    out_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES*WIDTH-1:0] stage_data;
  logic [OccW-1:0]         occupancy;

  modport master (
    output in_valid, in_data, stall, flush, out_ready,
    input  in_ready, out_valid, out_data, stage_valid, stage_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, stall, flush, out_ready,
    output in_ready, out_valid, out_data, stage_valid, stage_data, occupancy
  );
endinterface

// File: rtl/pipe_chain.sv
// Parametrised pipeline-register chain with per-stage stall/flush and valid tracking.
// COLLAPSE=1 closes bubbles and honours out_ready; COLLAPSE=0 loads every unstalled stage.
module pipe_chain #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned STAGES   = 5,
  parameter bit          COLLAPSE = 1'b1
) (
  input logic         clk,
  input logic         reset_n,
  pipe_chain_if.slave bus
);
  localparam int unsigned OccW = $clog2(STAGES + 1);

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]            load;
  logic [STAGES-1:0]            fv;
  logic [STAGES-1:0][WIDTH-1:0] fd;
  logic [OccW-1:0]              occ;

  // Acceptance ripples from the output end back to the input (combinational by design).
  always_comb begin
    logic down_acc;
    load     = '0;
    down_acc = COLLAPSE ? bus.out_ready : 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load[i]  = !bus.stall[i] && (!COLLAPSE || !valid_q[i] || down_acc);
      down_acc = load[i];
    end
  end

  // A stalled upstream stage forwards a bubble rather than a copy of its item.
  always_comb begin
    fv    = '0;
    fd    = '0;
    fv[0] = bus.in_valid;
    fd[0] = bus.in_data;
    for (int i = 1; i < STAGES; i++) begin
      fv[i] = valid_q[i-1] & ~bus.stall[i-1];
      fd[i] = data_q[i-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < STAGES; i++) begin
      if (bus.flush[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = '0;
      end else if (load[i]) begin
        valid_d[i] = fv[i];
        data_d[i]  = fd[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ = occ + OccW'(valid_q[i]);
    end
  end

  assign bus.in_ready    = load[0] & ~bus.flush[0];
  assign bus.out_valid   = valid_q[STAGES-1] & ~bus.stall[STAGES-1];
  assign bus.out_data    = data_q[STAGES-1];
  assign bus.stage_valid = valid_q;
  assign bus.stage_data  = data_q;
  assign bus.occupancy   = occ;
endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain: one elastic and one lockstep instance, directed vectors.
module tb_pipe_chain;
  localparam int unsigned W = 32;
  localparam int unsigned S = 5;

  typedef struct {
    logic [W-1:0] data;
    int           exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_c[$];
  exp_t q_l[$];

  pipe_chain_if #(.WIDTH(W), .STAGES(S)) bc ();
  pipe_chain_if #(.WIDTH(W), .STAGES(S)) bl ();

  pipe_chain #(.WIDTH(W), .STAGES(S), .COLLAPSE(1'b1)) dut_c (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bc)
  );

  pipe_chain #(.WIDTH(W), .STAGES(S), .COLLAPSE(1'b0)) dut_l (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: compare each transfer against the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && bc.out_valid && bc.out_ready) begin
      if (q_c.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c_unexpected_out: got %0h expected none", bc.out_data);
      end else begin
        exp_t e;
        e = q_c.pop_front();
        check("c_out_data", bc.out_data, e.data);
        if (e.exp_cyc >= 0) check("c_latency", cyc, e.exp_cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && bl.out_valid) begin
      if (q_l.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL l_unexpected_out: got %0h expected none", bl.out_data);
      end else begin
        exp_t e;
        e = q_l.pop_front();
        check("l_out_data", bl.out_data, e.data);
      end
    end
  end

  task automatic step_c(input logic v, input logic [W-1:0] d, input logic [S-1:0] st,
                        input logic [S-1:0] fl, input logic ordy, input logic rdy_exp,
                        input logic out_exp, input logic lat);
    @(posedge clk);
    #1;
    bc.in_valid  = v;
    bc.in_data   = d;
    bc.stall     = st;
    bc.flush     = fl;
    bc.out_ready = ordy;
    #1;
    check("c_in_ready", bc.in_ready, rdy_exp);
    if (v && rdy_exp && out_exp) q_c.push_back('{data: d, exp_cyc: lat ? cyc + 5 : -1});
  endtask

  task automatic idle_c(input int n);
    for (int k = 0; k < n; k++) step_c(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic step_l(input logic v, input logic [W-1:0] d, input logic [S-1:0] st,
                        input logic [S-1:0] fl, input logic rdy_exp, input logic out_exp);
    @(posedge clk);
    #1;
    bl.in_valid = v;
    bl.in_data  = d;
    bl.stall    = st;
    bl.flush    = fl;
    #1;
    check("l_in_ready", bl.in_ready, rdy_exp);
    if (v && rdy_exp && out_exp) q_l.push_back('{data: d, exp_cyc: -1});
  endtask

  initial begin
    bc.in_valid = 1'b0; bc.in_data = '0; bc.stall = '0; bc.flush = '0; bc.out_ready = 1'b1;
    bl.in_valid = 1'b0; bl.in_data = '0; bl.stall = '0; bl.flush = '0; bl.out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_stage_valid", bc.stage_valid, 0);
    check("rst_stage_data", bc.stage_data, 0);
    check("rst_out_valid", bc.out_valid, 0);
    check("rst_occupancy", bc.occupancy, 0);
    check("rst_in_ready", bc.in_ready, 1);
    #10 reset_n = 1'b1;

    // Streaming 0x11..0x15, latency S
    for (int k = 0; k < 5; k++) step_c(1'b1, W'(32'h11 + k), '0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    step_c(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("stream_occ_peak", bc.occupancy, 5);
    idle_c(6);
    check("stream_drained", bc.occupancy, 0);

    // Backpressure and bubble collapse
    step_c(1'b1, 32'hA1, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_c(1);
    step_c(1'b1, 32'hB2, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_c(2);
    step_c(1'b1, 32'hC3, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("bp_valid_p1", bc.stage_valid, 5'b10100);
    step_c(1'b1, 32'hD4, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("bp_valid_p2", bc.stage_valid, 5'b11001);
    check("bp_s3_data", bc.stage_data[3*W +: W], 32'hB2);
    step_c(1'b1, 32'hE5, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("bp_valid_p3", bc.stage_valid, 5'b11011);
    step_c(1'b1, 32'hF6, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_valid_full", bc.stage_valid, 5'b11111);
    check("bp_occ_full", bc.occupancy, 5);
    step_c(1'b1, 32'hF6, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_c(7);

    // Stall bubble on stage 1
    step_c(1'b1, 32'h31, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    step_c(1'b1, 32'h32, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    step_c(1'b1, 32'h33, 5'b00010, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    step_c(1'b1, 32'h33, 5'b00010, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("stall_bubble_s2", bc.stage_valid, 5'b00011);
    step_c(1'b1, 32'h33, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("stall_bubble_s3", bc.stage_valid, 5'b00011);
    step_c(1'b1, 32'h34, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    step_c(1'b1, 32'h35, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_c(7);

    // Flush + stall on stage 2: item dies, nothing forwarded
    step_c(1'b1, 32'h47, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_c(2);
    step_c(1'b0, '0, 5'b00100, 5'b00100, 1'b1, 1'b1, 1'b0, 1'b0);
    check("fs_pre_valid", bc.stage_valid, 5'b00100);
    check("fs_pre_data", bc.stage_data[2*W +: W], 32'h47);
    idle_c(1);
    check("fs_valid", bc.stage_valid, 5'b00000);
    check("fs_s2_data", bc.stage_data[2*W +: W], 0);
    idle_c(5);

    // Flush alone on stage 2: leaving item still reaches stage 3
    step_c(1'b1, 32'h48, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_c(2);
    step_c(1'b0, '0, '0, 5'b00100, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_c(1);
    check("f_valid", bc.stage_valid, 5'b01000);
    check("f_s3_data", bc.stage_data[3*W +: W], 32'h48);
    check("f_s2_data", bc.stage_data[2*W +: W], 0);
    idle_c(5);

    // Legacy lockstep mode with out_ready held low
    step_l(1'b1, 32'h51, '0, '0, 1'b1, 1'b1);
    step_l(1'b1, 32'h52, '0, '0, 1'b1, 1'b1);
    step_l(1'b1, 32'h53, '0, '0, 1'b1, 1'b1);
    step_l(1'b1, 32'h54, 5'b00111, '0, 1'b0, 1'b0);
    step_l(1'b1, 32'h54, '0, '0, 1'b1, 1'b0);
    check("leg_valid_x5", bl.stage_valid, 5'b00111);
    step_l(1'b1, 32'h55, '0, 5'b00010, 1'b1, 1'b1);
    step_l(1'b0, '0, '0, '0, 1'b1, 1'b0);
    check("leg_valid_x7", bl.stage_valid, 5'b11101);
    check("leg_s2_data", bl.stage_data[2*W +: W], 32'h53);
    for (int k = 0; k < 6; k++) step_l(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream
    step_c(1'b1, 32'h61, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    step_c(1'b1, 32'h62, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    step_c(1'b1, 32'h63, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ar_pre_occ", bc.occupancy, 2);
    #1 reset_n = 1'b0;
    bc.in_valid = 1'b0;
    #1;
    check("ar_stage_valid", bc.stage_valid, 0);
    check("ar_stage_data", bc.stage_data, 0);
    check("ar_out_valid", bc.out_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    step_c(1'b1, 32'h71, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle_c(7);

    check("c_queue_empty", q_c.size(), 0);
    check("l_queue_empty", q_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
